// File: rtl/trng_health_fifo.sv
// trng_health_fifo
//   Consumes the raw ring-oscillator XOR bit stream. A repetition-count test
//   watches the raw bits, an optional von Neumann stage removes bias, and the
//   accepted bits are packed MSB-first into bytes that are queued in a small
//   FIFO. Bytes, status and control are reached through a 4-bit register map:
//     0x0 DATA  rd: FIFO head (0x00 when empty); data_read pops it
//     0x1 STAT  rd: [0] nonempty [1] full [2] fault [3] overflow [7:4] count
//     0x2 CTRL  rd/wr: [0] ENABLE [1] DEBIAS; writing bit 7 also clears
//                      fault, overflow, FIFO and all bit-level state
//   Any other address reads 0x00 and ignores writes.
module trng_health_fifo #(
  parameter int FIFO_DEPTH = 4,   // byte entries, power of two, 2..8
  parameter int RCT_LIMIT  = 32   // identical raw bits that trip the fault, 2..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_bit,
  input  logic       raw_valid,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  input  logic       data_read,
  output logic [7:0] data_out,
  output logic       byte_ready,
  output logic       fault
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
  localparam logic [7:0]    RCT_LIMIT_C = 8'(RCT_LIMIT);

  localparam logic [3:0] ADDR_DATA = 4'h0;
  localparam logic [3:0] ADDR_STAT = 4'h1;
  localparam logic [3:0] ADDR_CTRL = 4'h2;

  // Control register
  logic enable;
  logic debias;

  // Repetition-count test state
  logic       rct_last;
  logic [7:0] rct_cnt;
  logic [7:0] rct_next;

  // Von Neumann pair state and byte packer
  logic       pair_have;
  logic       pair_first;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;

  // Byte FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          overflow;

  // Per-cycle decode
  logic       consume;
  logic       ctrl_wr;
  logic       ctrl_clear;
  logic       debias_chg;
  logic       empty;
  logic       full;
  logic       pop;
  logic       acc_valid;
  logic       acc_bit;
  logic       push_req;
  logic       push_ok;
  logic       push_drop;
  logic [7:0] push_byte;

  // Bits 6:2 of a CTRL write carry no meaning.
  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^data_in[6:2];

  assign consume    = enable && raw_valid;
  assign ctrl_wr    = data_write && (address == ADDR_CTRL);
  assign ctrl_clear = ctrl_wr && data_in[7];
  assign debias_chg = ctrl_wr && (data_in[1] != debias);

  assign empty      = (count == '0);
  assign full       = (count == DEPTH_C);
  assign pop        = data_read && (address == ADDR_DATA) && !empty;
  assign byte_ready = !empty;

  // Next repetition count for the incoming raw bit; a zero count means no
  // history yet, so the first bit after reset or clear starts a fresh run.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    rct_next = rct_cnt;
    if ((rct_cnt == 8'd0) || (raw_bit != rct_last)) begin
      rct_next = 8'd1;
    end else if (rct_cnt != RCT_LIMIT_C) begin
      rct_next = rct_cnt + 8'd1;
    end
  end

  // Debias decision: a bit is accepted either directly or on the second bit
  // of an unequal pair (01 -> 0, 10 -> 1, i.e. the first bit of the pair).
  // A registered fault halts the stage; the bit that trips it still counts.
  always_comb begin
    acc_valid = 1'b0;
    acc_bit   = 1'b0;
    if (consume && !fault) begin
      if (debias) begin
        if (pair_have && (pair_first != raw_bit)) begin
          acc_valid = 1'b1;
          acc_bit   = pair_first;
        end
      end else begin
        acc_valid = 1'b1;
        acc_bit   = raw_bit;
      end
    end
  end

  // The eighth accepted bit completes a byte and is pushed on the same edge.
  // A full FIFO still takes the byte when a pop happens on that edge.
  always_comb begin
    push_req  = acc_valid && (bit_cnt == 3'd7);
    push_byte = {shreg, acc_bit};
    push_ok   = push_req && (!full || pop);
    push_drop = push_req && full && !pop;
  end

  // CTRL register: ENABLE and DEBIAS are written on every CTRL write.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable <= 1'b0;
      debias <= 1'b1;
    end else if (ctrl_wr) begin
      enable <= data_in[0];
      debias <= data_in[1];
    end
  end

  // Repetition-count test on raw bits, independent of debias mode; the
  // fault flag is sticky until reset or a clearing CTRL write.
  always_ff @(posedge clk) begin
    if (rst || ctrl_clear) begin
      rct_cnt  <= 8'd0;
      rct_last <= 1'b0;
      fault    <= 1'b0;
    end else if (consume) begin
      rct_cnt  <= rct_next;
      rct_last <= raw_bit;
      if (rct_next == RCT_LIMIT_C) begin
        fault <= 1'b1;
      end
    end
  end

  // Pair tracking and MSB-first byte packing. A DEBIAS change drops a
  // half-collected pair but keeps the partial byte.
  always_ff @(posedge clk) begin
    if (rst || ctrl_clear) begin
      pair_have  <= 1'b0;
      pair_first <= 1'b0;
      bit_cnt    <= 3'd0;
      shreg      <= 7'd0;
    end else begin
      if (consume && !fault && debias) begin
        pair_have  <= !pair_have;
        pair_first <= raw_bit;
      end
      if (acc_valid) begin
        if (bit_cnt == 3'd7) begin
          bit_cnt <= 3'd0;
          shreg   <= 7'd0;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
          shreg   <= {shreg[5:0], acc_bit};
        end
      end
      if (debias_chg) begin
        pair_have <= 1'b0;
      end
    end
  end

  // FIFO pointers, occupancy and sticky overflow; pointers wrap naturally
  // because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst || ctrl_clear) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      if (push_ok && !pop) begin
        count <= count + 1'b1;
      end else if (!push_ok && pop) begin
        count <= count - 1'b1;
      end
      if (push_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // FIFO storage; entries are only observable through the pointers.
  // NOTE: the storage array has no reset: emptiness is defined by count, so
  // clearing it would only cost reset fan-out and block RAM inference.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= push_byte;
    end
  end

  // Register read mux, combinational from address and current state.
  always_comb begin
    data_out = 8'h00;
    case (address)
      ADDR_DATA: if (!empty) data_out = mem[rptr];
      ADDR_STAT: data_out = {4'(count), overflow, fault, full, !empty};
      ADDR_CTRL: data_out = {6'd0, debias, enable};
      default:   data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_trng_health_fifo.sv
// tb_trng_health_fifo
//   Directed scenarios followed by randomized traffic. A behavioural model
//   (queues of bits and bytes, integer run length) predicts every byte read
//   from DATA; expected bytes go into a scoreboard queue that a separate
//   monitor drains whenever a DATA read strobe is presented to the DUT.
module tb_trng_health_fifo;

  localparam int DEPTH = 4;
  localparam int LIMIT = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       raw_bit;
  logic       raw_valid;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic       data_read;
  logic [7:0] data_out;
  logic       byte_ready;
  logic       fault;

  trng_health_fifo #(.FIFO_DEPTH(DEPTH), .RCT_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_bit   (raw_bit),
    .raw_valid (raw_valid),
    .address   (address),
    .data_write(data_write),
    .data_in   (data_in),
    .data_read (data_read),
    .data_out  (data_out),
    .byte_ready(byte_ready),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];

  // Reference model state
  bit         m_enable;
  bit         m_debias;
  bit         m_fault;
  bit         m_ovf;
  bit         m_run_val;
  int         m_run_len;
  bit         m_pair_have;
  bit         m_pair_a;
  bit         m_bits[$];
  logic [7:0] m_fifo[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%02h expected=%02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_enable    = 1'b0;
    m_debias    = 1'b1;
    m_fault     = 1'b0;
    m_ovf       = 1'b0;
    m_run_val   = 1'b0;
    m_run_len   = 0;
    m_pair_have = 1'b0;
    m_pair_a    = 1'b0;
    m_bits.delete();
    m_fifo.delete();
  endfunction

  function automatic logic [7:0] model_stat();
    logic [7:0] s;
    s[7:4] = 4'(m_fifo.size());
    s[3]   = m_ovf;
    s[2]   = m_fault;
    s[1]   = (m_fifo.size() == DEPTH);
    s[0]   = (m_fifo.size() != 0);
    return s;
  endfunction

  function automatic void model_accept(input bit b, input bit will_pop);
    int v;
    m_bits.push_back(b);
    if (m_bits.size() == 8) begin
      v = 0;
      for (int i = 0; i < 8; i++) v = v * 2 + int'(m_bits[i]);
      m_bits.delete();
      if (m_fifo.size() >= DEPTH && !will_pop) m_ovf = 1'b1;
      else m_fifo.push_back(8'(v));
    end
  endfunction

  function automatic void model_raw(input bit b, input bit will_pop);
    bit halted;
    halted = m_fault;
    if (m_run_len == 0 || b != m_run_val) m_run_len = 1;
    else if (m_run_len < LIMIT) m_run_len++;
    m_run_val = b;
    if (m_run_len >= LIMIT) m_fault = 1'b1;
    if (halted) return;
    if (m_debias) begin
      if (!m_pair_have) begin
        m_pair_have = 1'b1;
        m_pair_a    = b;
      end else begin
        m_pair_have = 1'b0;
        if (m_pair_a != b) model_accept(m_pair_a, will_pop);
      end
    end else begin
      model_accept(b, will_pop);
    end
  endfunction

  function automatic void model_ctrl(input logic [7:0] v);
    if (v[7]) begin
      m_fault     = 1'b0;
      m_ovf       = 1'b0;
      m_run_len   = 0;
      m_pair_have = 1'b0;
      m_bits.delete();
      m_fifo.delete();
    end
    if (v[1] != m_debias) m_pair_have = 1'b0;
    m_enable = v[0];
    m_debias = v[1];
  endfunction

  // One clock of raw/read traffic; the expected DATA value is queued first.
  task automatic step(input bit rv, input bit rb, input bit rd);
    bit         will_pop;
    logic [7:0] tmp;
    raw_valid  = rv;
    raw_bit    = rb;
    data_read  = rd;
    address    = 4'h0;
    data_write = 1'b0;
    will_pop   = rd && (m_fifo.size() != 0);
    if (rd) exp_q.push_back((m_fifo.size() != 0) ? m_fifo[0] : 8'h00);
    if (rv && m_enable) model_raw(rb, will_pop);
    if (will_pop) tmp = m_fifo.pop_front();
    @(posedge clk); #1;
    raw_valid = 1'b0;
    data_read = 1'b0;
  endtask

  task automatic ctrl_write(input logic [7:0] v);
    address    = 4'h2;
    data_write = 1'b1;
    data_in    = v;
    model_ctrl(v);
    @(posedge clk); #1;
    data_write = 1'b0;
    address    = 4'h0;
    data_in    = 8'h00;
  endtask

  task automatic write_other(input logic [3:0] a, input logic [7:0] v);
    address    = a;
    data_write = 1'b1;
    data_in    = v;
    @(posedge clk); #1;
    data_write = 1'b0;
    address    = 4'h0;
    data_in    = 8'h00;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    raw_valid  = 1'b0;
    data_read  = 1'b0;
    data_write = 1'b0;
    address    = 4'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_regs(input string tag);
    address = 4'h1; #1;
    check({tag, "_stat"}, data_out, model_stat());
    address = 4'h2; #1;
    check({tag, "_ctrl"}, data_out, {6'd0, m_debias, m_enable});
    check({tag, "_fault_pin"}, 8'(fault), 8'(m_fault));
    check({tag, "_byte_ready"}, 8'(byte_ready), 8'(m_fifo.size() != 0));
    address = 4'h0; #1;
  endtask

  task automatic peek(input logic [3:0] a, input string name, input logic [7:0] exp);
    address = a; #1;
    check(name, data_out, exp);
    address = 4'h0;
  endtask

  task automatic feed_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(1'b1, v[i], 1'b0);
  endtask

  task automatic feed_byte_pairs(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      step(1'b1, v[i], 1'b0);
      step(1'b1, !v[i], 1'b0);
    end
  endtask

  // Scoreboard monitor: every DATA read strobe consumes one expectation.
  always @(negedge clk) begin
    if (!rst && data_read && address == 4'h0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_underflow actual=read expected=no_read at %0t", $time);
      end else begin
        check("sb_data", data_out, exp_q.pop_front());
      end
    end
  end

  logic [7:0] t4_bytes [5];
  logic [7:0] t5_bytes [5];
  int         seg;
  int         r;
  bit         rb;
  bit         rd;

  initial begin
    t4_bytes = '{8'hA5, 8'h3C, 8'h5A, 8'hC3, 8'h99};
    t5_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    rst = 1'b1; raw_bit = 1'b0; raw_valid = 1'b0; address = 4'h0;
    data_write = 1'b0; data_in = 8'h00; data_read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Reset state
    peek(4'h1, "rst_stat", 8'h00);
    peek(4'h0, "rst_data", 8'h00);
    peek(4'h2, "rst_ctrl", 8'h02);
    peek(4'h7, "rst_unmapped", 8'h00);
    check("rst_fault", 8'(fault), 8'h00);
    check("rst_byte_ready", 8'(byte_ready), 8'h00);

    // Writes to unmapped addresses are ignored
    write_other(4'h5, 8'hFF);
    peek(4'h2, "unmapped_wr_ctrl", 8'h02);

    // Plain packing, raw 1,0,1,1,0,0,1,0
    ctrl_write(8'h01);
    feed_byte(8'hB2);
    peek(4'h1, "t1_stat", 8'h11);
    peek(4'h0, "t1_data", 8'hB2);
    step(1'b0, 1'b0, 1'b1);
    peek(4'h1, "t1_stat_popped", 8'h00);

    // Debiased pairs 01,10,00,11,10,10,01,01,10,01 -> 0x72
    ctrl_write(8'h03);
    begin
      bit pr [20];
      pr = '{0,1, 1,0, 0,0, 1,1, 1,0, 1,0, 0,1, 0,1, 1,0, 0,1};
      for (int i = 0; i < 20; i++) step(1'b1, pr[i], 1'b0);
    end
    peek(4'h0, "t2_data", 8'h72);
    step(1'b0, 1'b0, 1'b1);

    // Repetition-count fault on the 32nd identical bit, then recovery
    ctrl_write(8'h83);
    for (int i = 0; i < LIMIT - 1; i++) step(1'b1, 1'b1, 1'b0);
    check("t3_fault_before", 8'(fault), 8'h00);
    step(1'b1, 1'b1, 1'b0);
    check("t3_fault_set", 8'(fault), 8'h01);
    peek(4'h1, "t3_stat_fault", 8'h04);
    ctrl_write(8'h83);
    peek(4'h1, "t3_stat_cleared", 8'h00);
    feed_byte_pairs(8'h5C);
    peek(4'h1, "t3_stat_resume", 8'h11);
    peek(4'h0, "t3_data_resume", 8'h5C);
    step(1'b0, 1'b0, 1'b1);

    // Overflow: fifth byte into a full FIFO is dropped
    ctrl_write(8'h81);
    for (int i = 0; i < 4; i++) feed_byte(t4_bytes[i]);
    peek(4'h1, "t4_stat_full", 8'h43);
    feed_byte(t4_bytes[4]);
    peek(4'h1, "t4_stat_ovf", 8'h4B);
    for (int i = 0; i < 4; i++) begin
      peek(4'h0, "t4_order", t4_bytes[i]);
      step(1'b0, 1'b0, 1'b1);
    end
    peek(4'h1, "t4_stat_drained", 8'h08);

    // Push and pop on the same edge while full
    ctrl_write(8'h81);
    for (int i = 0; i < 4; i++) feed_byte(t5_bytes[i]);
    for (int i = 7; i >= 1; i--) step(1'b1, t5_bytes[4][i], 1'b0);
    step(1'b1, t5_bytes[4][0], 1'b1);
    peek(4'h1, "t5_stat", 8'h43);
    for (int i = 1; i < 5; i++) begin
      peek(4'h0, "t5_order", t5_bytes[i]);
      step(1'b0, 1'b0, 1'b1);
    end

    // Reset mid-byte discards partial state
    ctrl_write(8'h81);
    for (int i = 0; i < 5; i++) step(1'b1, i[0], 1'b0);
    do_reset();
    peek(4'h1, "t6_stat", 8'h00);
    peek(4'h2, "t6_ctrl", 8'h02);
    ctrl_write(8'h01);
    feed_byte(8'hE7);
    peek(4'h1, "t6_stat_byte", 8'h11);
    peek(4'h0, "t6_data", 8'hE7);
    step(1'b0, 1'b0, 1'b1);

    // Randomized traffic against the model
    ctrl_write(8'h83);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      seg = (cyc / 250) % 4;
      r   = $urandom_range(0, 199);
      if (r < 4) begin
        ctrl_write({(r == 0), 5'd0, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 7) != 0)});
      end else if (r == 4) begin
        write_other(4'($urandom_range(3, 15)), 8'($urandom_range(0, 255)));
      end else if (r == 5) begin
        do_reset();
        ctrl_write(8'h01);
      end else begin
        rb = (seg[0]) ? ($urandom_range(0, 19) != 0) : 1'($urandom_range(0, 1));
        rd = (seg[1]) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) == 0);
        step(1'($urandom_range(0, 3) != 0), rb, rd);
      end
      if (cyc % 8 == 0) check_regs("rand");
    end

    @(posedge clk); #1;
    check("sb_drained", 8'(exp_q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
